sp_req_queue: RTL and testbench

Receive-side request queue that sits between the execute stage and the matrix scratchpad. It captures the one-cycle `sp_write` request pulses for matrix load, matrix store and GEMM operations into a small FIFO. It issues them to the scratchpad one at a time over a valid/ready handshake, tracks the single in-flight operation until the scratchpad reports done, and returns the matching `load_complete` / `store_complete` / `gemm_complete` pulse, which execute forwards to the scoreboard.

---
 rtl/sp_req_queue_if.sv | 22 ++
 rtl/sp_req_queue.sv | 157 +++++++++++++++
 tb/tb_sp_req_queue.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_req_queue_if.sv
// Scratchpad request channel: issued request fields with valid/ready, plus the done return.
interface sp_req_queue_if #(
  parameter int AW = 32
);
  logic          sp_req_valid;
  logic [1:0]    sp_req_kind;
  logic [3:0]    sp_req_rd;
  logic [AW-1:0] sp_req_addr;
  logic [AW-1:0] sp_req_stride;
  logic          sp_req_ready;
  logic          sp_done;

  modport master (
    output sp_req_valid, sp_req_kind, sp_req_rd, sp_req_addr, sp_req_stride,
    input  sp_req_ready, sp_done
  );

  modport slave (
    input  sp_req_valid, sp_req_kind, sp_req_rd, sp_req_addr, sp_req_stride,
    output sp_req_ready, sp_done
  );
endinterface

// File: rtl/sp_req_queue.sv
// Queues load/store/gemm requests, issues one at a time (write->valid in 2 cycles), holds while !ready, pulses completion.
// SP_REQ_BYPASS_EN: an idle, empty queue loads a new request straight into the issue register (1 cycle).
module sp_req_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   sp_write,
  input  logic [1:0]             sp_kind,
  input  logic [3:0]             sp_rd,
  input  logic [AW-1:0]          sp_addr,
  input  logic [AW-1:0]          sp_stride,
  input  logic                   flush,
  sp_req_queue_if.master         sp,
  output logic                   load_complete,
  output logic                   store_complete,
  output logic                   gemm_complete,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0]    kind;
    logic [3:0]    rd;
    logic [AW-1:0] addr;
    logic [AW-1:0] stride;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  req_t          mem_q [DEPTH];
  req_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  req_t          issue_q, issue_d;
  logic          err_q, err_d;
  logic [2:0]    done_q, done_d;   // {gemm, store, load}

  req_t in_req;
  logic legal, is_full, pop, push, bypass, overflow;

  assign in_req   = '{kind: sp_kind, rd: sp_rd, addr: sp_addr, stride: sp_stride};
  assign legal    = (sp_kind != 2'b11);
  assign is_full  = (count_q == CW'(DEPTH));
  assign pop      = (state_q == IDLE) && (count_q != '0) && !flush;

`ifdef SP_REQ_BYPASS_EN
  assign bypass   = (state_q == IDLE) && (count_q == '0) && sp_write && legal && !flush;
`else
  assign bypass   = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a write at full is still accepted.
  assign push     = sp_write && legal && !flush && !bypass && (!is_full || pop);
  assign overflow = sp_write && legal && !flush && is_full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | overflow | (sp_write && !legal);

    if (push) begin
      mem_d[wr_ptr_q] = in_req;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    done_d  = '0;

    case (state_q)
      IDLE: begin
        if (pop) begin
          issue_d = mem_q[rd_ptr_q];
          state_d = ISSUE;
        end else if (bypass) begin
          issue_d = in_req;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (sp.sp_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sp.sp_done) begin
          done_d[0] = (issue_q.kind == 2'b00);
          done_d[1] = (issue_q.kind == 2'b01);
          done_d[2] = (issue_q.kind == 2'b10);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      issue_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      issue_q  <= issue_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign sp.sp_req_valid  = (state_q == ISSUE);
  assign sp.sp_req_kind   = issue_q.kind;
  assign sp.sp_req_rd     = issue_q.rd;
  assign sp.sp_req_addr   = issue_q.addr;
  assign sp.sp_req_stride = issue_q.stride;

  assign load_complete  = done_q[0];
  assign store_complete = done_q[1];
  assign gemm_complete  = done_q[2];
  assign full           = is_full;
  assign count          = count_q;
  assign err            = err_q;
endmodule

// File: tb/tb_sp_req_queue.sv
// Bench for sp_req_queue: directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_sp_req_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
`ifdef SP_REQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          nRST;
  logic          sp_write;
  logic [1:0]    sp_kind;
  logic [3:0]    sp_rd;
  logic [AW-1:0] sp_addr;
  logic [AW-1:0] sp_stride;
  logic          flush;
  logic          load_complete, store_complete, gemm_complete;
  logic          full;
  logic [$clog2(DEPTH):0] count;
  logic          err;

  sp_req_queue_if #(.AW(AW)) sp ();

  sp_req_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .sp_write       (sp_write),
    .sp_kind        (sp_kind),
    .sp_rd          (sp_rd),
    .sp_addr        (sp_addr),
    .sp_stride      (sp_stride),
    .flush          (flush),
    .sp             (sp),
    .load_complete  (load_complete),
    .store_complete (store_complete),
    .gemm_complete  (gemm_complete),
    .full           (full),
    .count          (count),
    .err            (err)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of pending requests plus one request being serviced.
  typedef struct packed {
    logic [1:0]    kind;
    logic [3:0]    rd;
    logic [AW-1:0] addr;
    logic [AW-1:0] stride;
  } mreq_t;

  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2;

  mreq_t    mq[$];
  int       m_phase;
  mreq_t    m_cur;
  bit [2:0] m_pulse;
  bit       m_err;

  function automatic void model_reset();
    mq.delete();
    m_phase = P_IDLE;
    m_cur   = '0;
    m_pulse = '0;
    m_err   = 1'b0;
  endfunction

  function automatic void model_step();
    mreq_t req;
    bit    legal, pop, byp;
    int    n;
    req     = '{kind: sp_kind, rd: sp_rd, addr: sp_addr, stride: sp_stride};
    legal   = (sp_kind != 2'b11);
    n       = mq.size();
    pop     = (m_phase == P_IDLE) && (n > 0) && !flush;
    byp     = BYP && (m_phase == P_IDLE) && (n == 0) && sp_write && legal && !flush;
    m_pulse = '0;

    if (m_phase == P_IDLE) begin
      if (pop) begin
        m_cur   = mq.pop_front();
        m_phase = P_ISSUE;
      end else if (byp) begin
        m_cur   = req;
        m_phase = P_ISSUE;
      end
    end else if (m_phase == P_ISSUE) begin
      if (sp.sp_req_ready) m_phase = P_WAIT;
    end else begin
      if (sp.sp_done) begin
        m_pulse = 3'b001 << m_cur.kind;
        m_phase = P_IDLE;
      end
    end

    if (sp_write && !legal) begin
      m_err = 1'b1;
    end else if (sp_write && !flush && !byp) begin
      if (n < DEPTH || pop) mq.push_back(req);
      else                  m_err = 1'b1;
    end
    if (flush) mq.delete();
  endfunction

  task automatic check_outputs();
    check_eq("req_valid",  sp.sp_req_valid,  m_phase == P_ISSUE);
    check_eq("req_kind",   sp.sp_req_kind,   m_cur.kind);
    check_eq("req_rd",     sp.sp_req_rd,     m_cur.rd);
    check_eq("req_addr",   sp.sp_req_addr,   m_cur.addr);
    check_eq("req_stride", sp.sp_req_stride, m_cur.stride);
    check_eq("load_cmpl",  load_complete,    m_pulse[0]);
    check_eq("store_cmpl", store_complete,   m_pulse[1]);
    check_eq("gemm_cmpl",  gemm_complete,    m_pulse[2]);
    check_eq("full",       full,             mq.size() == DEPTH);
    check_eq("count",      count,            mq.size());
    check_eq("err",        err,              m_err);
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (nRST) model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit w, input bit [1:0] k, input bit [3:0] rd,
                       input logic [AW-1:0] a, input logic [AW-1:0] s);
    sp_write  = w;
    sp_kind   = k;
    sp_rd     = rd;
    sp_addr   = a;
    sp_stride = s;
  endtask

  task automatic do_reset();
    nRST            = 1'b0;
    drive(0, 0, 0, '0, '0);
    flush           = 1'b0;
    sp.sp_req_ready = 1'b0;
    sp.sp_done      = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic fill_five();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'(i % 2), 4'(i), AW'(32'h1000 + i * 16), AW'(8));
      cycle();
    end
    drive(0, 0, 0, '0, '0);
  endtask

  initial begin
    do_reset();

    // Single load, ready held high
    sp.sp_req_ready = 1'b1;
    drive(1, 2'b00, 4'd3, AW'(32'h100), AW'(8));
    cycle();
    drive(0, 0, 0, '0, '0);
    check_eq("lat_n1_valid", sp.sp_req_valid, BYP);
    cycle();
    check_eq("lat_n2_valid", sp.sp_req_valid, !BYP);
    check_eq("lat_addr", sp.sp_req_addr, AW'(32'h100));
    cycle();
    sp.sp_done = 1'b1;
    cycle();
    sp.sp_done = 1'b0;
    check_eq("load_pulse", load_complete, 1'b1);
    cycle();
    check_eq("load_pulse_end", load_complete, 1'b0);

    // Fill with ready low, overflow, then drain in order
    do_reset();
    fill_five();
    check_eq("fill_count", count, 4);
    check_eq("fill_full", full, 1'b1);
    drive(1, 2'b01, 4'd9, AW'(32'hDEAD), AW'(4));
    cycle();
    drive(0, 0, 0, '0, '0);
    check_eq("ovf_err", err, 1'b1);
    check_eq("ovf_count", count, 4);
    sp.sp_req_ready = 1'b1;
    sp.sp_done      = 1'b1;
    repeat (25) cycle();

    // Push and pop together while full
    do_reset();
    fill_five();
    sp.sp_req_ready = 1'b1;
    cycle();
    sp.sp_req_ready = 1'b0;
    sp.sp_done      = 1'b1;
    cycle();
    sp.sp_done = 1'b0;
    drive(1, 2'b10, 4'd7, AW'(32'h2000), AW'(64));
    cycle();
    drive(0, 0, 0, '0, '0);
    check_eq("pp_count", count, 4);
    check_eq("pp_err", err, 1'b0);
    sp.sp_req_ready = 1'b1;
    sp.sp_done      = 1'b1;
    repeat (25) cycle();

    // Illegal kind
    do_reset();
    drive(1, 2'b11, 4'd1, AW'(32'h40), AW'(4));
    cycle();
    drive(0, 0, 0, '0, '0);
    check_eq("ill_count", count, 0);
    check_eq("ill_err", err, 1'b1);
    repeat (3) cycle();
    check_eq("ill_no_issue", sp.sp_req_valid, 1'b0);

    // Flush while a store is in WAIT
    do_reset();
    drive(1, 2'b01, 4'd5, AW'(32'h300), AW'(16));
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b00, 4'(i), AW'(32'h400 + i * 4), AW'(4));
      cycle();
    end
    drive(0, 0, 0, '0, '0);
    cycle();
    check_eq("fl_pre_count", count, 3);
    sp.sp_req_ready = 1'b1;
    cycle();
    sp.sp_req_ready = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check_eq("fl_count", count, 0);
    sp.sp_done = 1'b1;
    cycle();
    sp.sp_done = 1'b0;
    check_eq("fl_store_pulse", store_complete, 1'b1);
    repeat (5) cycle();
    check_eq("fl_no_issue", sp.sp_req_valid, 1'b0);

    // Reset while waiting, then a stray done
    do_reset();
    sp.sp_req_ready = 1'b1;
    drive(1, 2'b00, 4'd2, AW'(32'h500), AW'(8));
    cycle();
    drive(0, 0, 0, '0, '0);
    repeat (3) cycle();
    do_reset();
    sp.sp_done = 1'b1;
    cycle();
    sp.sp_done = 1'b0;
    check_eq("rst_stray_done", load_complete, 1'b0);
    cycle();

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 3) == 0,
            (($urandom % 64) == 0) ? 2'b11 : 2'($urandom % 3),
            4'($urandom), AW'($urandom), AW'($urandom));
      flush           = (($urandom % 40) == 0);
      sp.sp_req_ready = $urandom % 2;
      sp.sp_done      = (($urandom % 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
